// File: rtl/spi_target_regfile.sv
// SPI mode-0 target with an 8 x 8-bit register file, oversampled on the system clock.
// Register 7 is read-only and returns ID_VALUE; the address auto-increments through bursts.
module spi_target_regfile #(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe,
    output logic [7:0] reg0_o,
    output logic       wr_strobe_o,
    output logic [2:0] wr_addr_o,
    output logic       frame_done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync_p0, cs_sync_p0, mosi_sync_p0;
    logic                   sck_p1, cs_p1, mosi_p1;
    logic                   sck_prev_p2, cs_prev_p2;
    logic                   armed;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;

    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [2:0] addr;
    logic       rw;
    logic       load_pend;
    logic       byte_seen;
    logic [6:0] shift_in;
    logic [7:0] shift_out;
    logic [7:0] byte_in;
    logic [7:0] rd_data;
    logic [7:0] regs [0:6];

    // Stage p0/p1: synchronizer chain; p1 is the last synchronized value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_p0  <= '0;
            cs_sync_p0   <= '0;
            mosi_sync_p0 <= '0;
            sck_prev_p2  <= 1'b0;
            cs_prev_p2   <= 1'b0;
            armed        <= 1'b0;
        end else begin
            sck_sync_p0  <= {sck_sync_p0[SYNC_STAGES-2:0], sck_i};
            cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], mosi_i};
            sck_prev_p2  <= sck_p1;
            cs_prev_p2   <= cs_p1;
            // A frame already running when reset released must see cs_n high before it counts
            if (cs_p1)
                armed <= 1'b1;
        end
    end

    assign sck_p1  = sck_sync_p0[SYNC_STAGES-1];
    assign cs_p1   = cs_sync_p0[SYNC_STAGES-1];
    assign mosi_p1 = mosi_sync_p0[SYNC_STAGES-1];

    // Stage p2: edge detection against the previous synchronized value
    assign sck_rise = sck_p1 & ~sck_prev_p2;
    assign sck_fall = ~sck_p1 & sck_prev_p2;
    assign cs_fall  = ~cs_p1 & cs_prev_p2 & armed;
    assign cs_rise  = cs_p1 & ~cs_prev_p2;

    assign byte_in = {shift_in, mosi_p1};

    always_comb begin
        rd_data = ID_VALUE;
        for (int i = 0; i < 7; i++)
            if (addr == 3'(i))
                rd_data = regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= 3'd0;
            addr         <= 3'd0;
            rw           <= 1'b0;
            load_pend    <= 1'b0;
            byte_seen    <= 1'b0;
            shift_in     <= 7'd0;
            shift_out    <= 8'd0;
            wr_strobe_o  <= 1'b0;
            wr_addr_o    <= 3'd0;
            frame_done_o <= 1'b0;
            for (int i = 0; i < 7; i++)
                regs[i] <= 8'd0;
        end else begin
            wr_strobe_o  <= 1'b0;
            frame_done_o <= 1'b0;
            if (cs_rise) begin
                frame_done_o <= (state != ST_IDLE) && byte_seen;
                state        <= ST_IDLE;
                load_pend    <= 1'b0;
                shift_out    <= 8'd0;
            end else if (cs_fall) begin
                state     <= ST_CMD;
                bit_cnt   <= 3'd0;
                byte_seen <= 1'b0;
                load_pend <= 1'b0;
                rw        <= 1'b0;
                shift_out <= 8'd0;
            end else if (state != ST_IDLE) begin
                if (sck_rise) begin
                    shift_in <= byte_in[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_seen <= 1'b1;
                        if (state == ST_CMD) begin
                            rw        <= byte_in[7];
                            addr      <= byte_in[2:0];
                            load_pend <= byte_in[7];
                            state     <= ST_DATA;
                        end else begin
                            addr      <= addr + 3'd1;
                            load_pend <= rw;
                            if (!rw && addr != 3'd7) begin
                                for (int i = 0; i < 7; i++)
                                    if (addr == 3'(i))
                                        regs[i] <= byte_in;
                                wr_strobe_o <= 1'b1;
                                wr_addr_o   <= addr;
                            end
                        end
                    end
                end else if (sck_fall) begin
                    // The first falling edge after a byte boundary presents the next read byte
                    if (load_pend) begin
                        shift_out <= rd_data;
                        load_pend <= 1'b0;
                    end else begin
                        shift_out <= {shift_out[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign miso_o  = shift_out[7];
    assign miso_oe = ~cs_p1 & armed;
    assign reg0_o  = regs[0];

endmodule

// File: tb/tb_spi_target_regfile.sv
// Directed bench for spi_target_regfile: table-driven frames plus abort, reset and burst sequences.
module tb_spi_target_regfile;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [7:0] reg0;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic       frame_done;

    spi_target_regfile #(.ID_VALUE(8'hA5), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sck_i        (sck),
        .cs_n_i       (cs_n),
        .mosi_i       (mosi),
        .miso_o       (miso),
        .miso_oe      (miso_oe),
        .reg0_o       (reg0),
        .wr_strobe_o  (wr_strobe),
        .wr_addr_o    (wr_addr),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    int strobe_cnt = 0;
    int done_cnt   = 0;
    always @(posedge clk) begin
        if (wr_strobe)  strobe_cnt <= strobe_cnt + 1;
        if (frame_done) done_cnt   <= done_cnt + 1;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    logic [7:0] tx_buf [0:16];
    logic [7:0] rx_buf [0:16];

    // Shift nb bits MSB-first at f_clk/8; miso is captured where the master would, at sck rise
    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i > 7 - nb; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = miso;
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic do_frame(input int n);
        logic [7:0] r;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < n; b++) begin
            spi_bits(tx_buf[b], 8, r);
            rx_buf[b] = r;
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        string           name;
        int              n;
        logic [3:0][7:0] tx;
        logic [3:0][7:0] rx;
        logic [3:0]      rx_mask;
        int              strobes;
        logic [2:0]      waddr;
        logic [7:0]      reg0;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] model [0:7];
    logic [7:0] r;
    logic [2:0] a;
    int         s0, d0, exp_strobes;

    initial begin
        vecs[0] = '{"wr_reg1",   2, {8'h00, 8'h00, 8'h3C, 8'h01}, 32'h0,                         4'b0001, 1, 3'd1, 8'h00};
        vecs[1] = '{"rd_reg1",   2, {8'h00, 8'h00, 8'h00, 8'h81}, {8'h00, 8'h00, 8'h3C, 8'h00}, 4'b0011, 0, 3'd1, 8'h00};
        vecs[2] = '{"rd_id",     2, {8'h00, 8'h00, 8'h00, 8'h87}, {8'h00, 8'h00, 8'hA5, 8'h00}, 4'b0011, 0, 3'd1, 8'h00};
        vecs[3] = '{"wr_id",     2, {8'h00, 8'h00, 8'h00, 8'h07}, 32'h0,                         4'b0000, 0, 3'd1, 8'h00};
        vecs[4] = '{"rd_id2",    2, {8'h00, 8'h00, 8'h00, 8'h87}, {8'h00, 8'h00, 8'hA5, 8'h00}, 4'b0011, 0, 3'd1, 8'h00};
        vecs[5] = '{"wr_burst",  4, {8'h33, 8'h22, 8'h11, 8'h06}, 32'h0,                         4'b0000, 2, 3'd0, 8'h33};
        vecs[6] = '{"rd_burst",  4, {8'h00, 8'h00, 8'h00, 8'h86}, {8'h33, 8'hA5, 8'h11, 8'h00}, 4'b1111, 0, 3'd0, 8'h33};
        vecs[7] = '{"wr_reg5",   2, {8'h00, 8'h00, 8'h5A, 8'h05}, 32'h0,                         4'b0000, 1, 3'd5, 8'h33};

        repeat (5) @(negedge clk);
        chk("rst_miso",   32'(miso), 32'h0);
        chk("rst_oe",     32'(miso_oe), 32'h0);
        chk("rst_strobe", 32'(wr_strobe), 32'h0);
        chk("rst_done",   32'(frame_done), 32'h0);
        chk("rst_waddr",  32'(wr_addr), 32'h0);
        chk("rst_reg0",   32'(reg0), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            s0 = strobe_cnt;
            d0 = done_cnt;
            for (int b = 0; b < vecs[i].n; b++) tx_buf[b] = vecs[i].tx[b];
            do_frame(vecs[i].n);
            for (int b = 0; b < 4; b++)
                if (vecs[i].rx_mask[b])
                    chk($sformatf("%s_rx%0d", vecs[i].name, b), 32'(rx_buf[b]), 32'(vecs[i].rx[b]));
            chk({vecs[i].name, "_strobes"}, 32'(strobe_cnt - s0), 32'(vecs[i].strobes));
            chk({vecs[i].name, "_done"},    32'(done_cnt - d0),   32'd1);
            chk({vecs[i].name, "_waddr"},   32'(wr_addr),         32'(vecs[i].waddr));
            chk({vecs[i].name, "_reg0"},    32'(reg0),            32'(vecs[i].reg0));
        end

        // Abort after five data bits: partial byte discarded, frame still counted
        s0 = strobe_cnt;
        d0 = done_cnt;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_oe", 32'(miso_oe), 32'h1);
        spi_bits(8'h02, 8, r);
        spi_bits(8'hFF, 5, r);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_strobes", 32'(strobe_cnt - s0), 32'd0);
        chk("abort_done",    32'(done_cnt - d0),   32'd1);
        tx_buf[0] = 8'h82;
        tx_buf[1] = 8'h00;
        do_frame(2);
        chk("abort_reg2", 32'(rx_buf[1]), 32'h00);

        // Abort inside the command byte: no frame_done
        d0 = done_cnt;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(8'h81, 3, r);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("short_abort_done", 32'(done_cnt - d0), 32'd0);

        // Reset in the middle of a write data byte
        s0 = strobe_cnt;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h55, 4, r);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_miso",   32'(miso), 32'h0);
        chk("mid_rst_oe",     32'(miso_oe), 32'h0);
        chk("mid_rst_strobe", 32'(wr_strobe), 32'h0);
        chk("mid_rst_done",   32'(frame_done), 32'h0);
        chk("mid_rst_waddr",  32'(wr_addr), 32'h0);
        chk("mid_rst_reg0",   32'(reg0), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        spi_bits(8'h50, 4, r);
        spi_bits(8'h55, 8, r);
        spi_bits(8'h55, 8, r);
        repeat (4) @(negedge clk);
        chk("stale_frame_oe", 32'(miso_oe), 32'h0);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("stale_frame_strobes", 32'(strobe_cnt - s0), 32'd0);
        chk("stale_frame_done",    32'(done_cnt - d0),   32'd0);
        chk("stale_frame_reg0",    32'(reg0),            32'h00);
        s0 = strobe_cnt;
        tx_buf[0] = 8'h00;
        tx_buf[1] = 8'h55;
        do_frame(2);
        chk("post_rst_reg0",    32'(reg0), 32'h55);
        chk("post_rst_strobes", 32'(strobe_cnt - s0), 32'd1);

        for (int k = 0; k < 7; k++) model[k] = 8'h00;
        model[0] = 8'h55;
        model[7] = 8'hA5;

        // Random 16-byte bursts at f_clk/8 against the register model
        for (int round = 0; round < 2; round++) begin
            a = 3'($urandom_range(0, 7));
            tx_buf[0] = {1'b0, 4'($urandom), a};
            exp_strobes = 0;
            for (int k = 0; k < 16; k++) begin
                tx_buf[k + 1] = 8'($urandom);
                if (3'(a + k) != 3'd7) begin
                    model[3'(a + k)] = tx_buf[k + 1];
                    exp_strobes++;
                end
            end
            s0 = strobe_cnt;
            do_frame(17);
            chk($sformatf("rnd%0d_strobes", round), 32'(strobe_cnt - s0), 32'(exp_strobes));
            chk($sformatf("rnd%0d_reg0", round),    32'(reg0),            32'(model[0]));
            tx_buf[0] = {1'b1, 4'($urandom), a};
            for (int k = 0; k < 16; k++) tx_buf[k + 1] = 8'($urandom);
            do_frame(17);
            for (int k = 0; k < 16; k++)
                chk($sformatf("rnd%0d_rd%0d", round, k), 32'(rx_buf[k + 1]), 32'(model[3'(a + k)]));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
